// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operands and opcode in, registered result out.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic [3:0]       ALUCtrl_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic             zero_o;

    modport master (
        output valid_i, data1_i, data2_i, ALUCtrl_i,
        input  ready_o, valid_o, data_o, zero_o
    );

    modport slave (
        input  valid_i, data1_i, data2_i, ALUCtrl_i,
        output ready_o, valid_o, data_o, zero_o
    );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/shift/add/compare, iterative WIDTH-cycle MUL.
// Define ALU_SEQ_DIV_EN to add the iterative restoring DIVU/REMU engine.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic        clk_i,
    input logic        rst_i,
    alu_seq_if.slave   bus
);
    localparam logic [3:0] OpAnd  = 4'd0;
    localparam logic [3:0] OpXor  = 4'd1;
    localparam logic [3:0] OpSll  = 4'd2;
    localparam logic [3:0] OpAdd  = 4'd3;
    localparam logic [3:0] OpSub  = 4'd4;
    localparam logic [3:0] OpMul  = 4'd5;
    localparam logic [3:0] OpSlt  = 4'd6;
    localparam logic [3:0] OpSra  = 4'd7;
    localparam logic [3:0] OpOr   = 4'd8;
    localparam logic [3:0] OpSrl  = 4'd9;
    localparam logic [3:0] OpSltu = 4'd10;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [3:0] OpDivu = 4'd11;
    localparam logic [3:0] OpRemu = 4'd12;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
`else
    typedef enum logic [1:0] {StIdle, StMul} state_e;
`endif

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             zero_q, zero_d;
    // mcand: multiplicand / divisor; mplier: multiplier / dividend-quotient; acc: product / remainder
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] acc_step;
    logic             last_iter;

`ifdef ALU_SEQ_DIV_EN
    logic             is_rem_q, is_rem_d;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] quo_new;
    logic             rem_ge;

    always_comb begin
        rem_shift = {acc_q, mplier_q[WIDTH-1]};
        rem_ge    = rem_shift >= {1'b0, mcand_q};
        // Difference always fits in WIDTH bits because the partial remainder is < 2*divisor
        rem_sub   = rem_shift[WIDTH-1:0] - mcand_q;
        rem_new   = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
        quo_new   = {mplier_q[WIDTH-2:0], rem_ge};
    end
`endif

    assign shamt     = bus.data2_i[SHW-1:0];
    assign acc_step  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign last_iter = (cnt_q == SHW'(WIDTH - 1));

    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl_i)
            OpAnd:   alu_res = bus.data1_i & bus.data2_i;
            OpXor:   alu_res = bus.data1_i ^ bus.data2_i;
            OpSll:   alu_res = bus.data1_i << shamt;
            OpAdd:   alu_res = bus.data1_i + bus.data2_i;
            OpSub:   alu_res = bus.data1_i - bus.data2_i;
            OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.data1_i) < $signed(bus.data2_i)};
            OpSra:   alu_res = $signed(bus.data1_i) >>> shamt;
            OpOr:    alu_res = bus.data1_i | bus.data2_i;
            OpSrl:   alu_res = bus.data1_i >> shamt;
            OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, bus.data1_i < bus.data2_i};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        data_d   = data_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`ifdef ALU_SEQ_DIV_EN
        is_rem_d = is_rem_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.valid_i) begin
                    case (bus.ALUCtrl_i)
                        OpMul: begin
                            state_d  = StMul;
                            mcand_d  = bus.data1_i;
                            mplier_d = bus.data2_i;
                            acc_d    = '0;
                            cnt_d    = '0;
                        end
`ifdef ALU_SEQ_DIV_EN
                        OpDivu, OpRemu: begin
                            state_d  = StDiv;
                            mcand_d  = bus.data2_i;
                            mplier_d = bus.data1_i;
                            acc_d    = '0;
                            cnt_d    = '0;
                            is_rem_d = (bus.ALUCtrl_i == OpRemu);
                        end
`endif
                        default: begin
                            valid_d = 1'b1;
                            data_d  = alu_res;
                            zero_d  = (alu_res == '0);
                        end
                    endcase
                end
            end
            StMul: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                    data_d  = acc_step;
                    zero_d  = (acc_step == '0);
                end
            end
`ifdef ALU_SEQ_DIV_EN
            StDiv: begin
                acc_d    = rem_new;
                mplier_d = quo_new;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d = StIdle;
                    valid_d = 1'b1;
                    data_d  = is_rem_q ? rem_new : quo_new;
                    zero_d  = ((is_rem_q ? rem_new : quo_new) == '0);
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            valid_q  <= 1'b0;
            data_q   <= '0;
            zero_q   <= 1'b1;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_rem_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
`ifdef ALU_SEQ_DIV_EN
            is_rem_q <= is_rem_d;
`endif
        end
    end

    assign bus.ready_o = (state_q == StIdle);
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.zero_o  = zero_q;
endmodule
